// File: rtl/inst_fetcher.sv
// Instruction fetch front-end: holds the PC, runs the memory fetch handshake, applies
// static next-PC prediction and hands one word at a time to the Issue queue.
module inst_fetcher #(
  parameter logic [31:0] RESET_PC      = 32'h0,
  parameter bit          PREDICT_TAKEN = 1'b1
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        _clear,
  input  logic [31:0] _clear_pc,
  input  logic        _need_inst,
  output logic [31:0] _inst_out,
  output logic        _inst_ready_out,
  output logic [31:0] _inst_addr_out,
  output logic        _mem_req,
  output logic [31:0] _mem_addr,
  input  logic [31:0] _mem_data,
  input  logic        _mem_done
);
  typedef enum logic [1:0] {REQ, WAIT, HOLD, STALL} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] hold_buf;
  logic        discard;

  logic [31:0] dlv_word;
  logic [31:0] imm_j;
  logic [31:0] imm_b;
  logic [31:0] next_pc;
  logic        next_stall;
  logic        deliver;

  // Next PC is decoded from whichever word is being handed over this cycle.
  always_comb begin
    dlv_word   = (state == HOLD) ? hold_buf : _mem_data;
    imm_j      = {{11{dlv_word[31]}}, dlv_word[31], dlv_word[19:12], dlv_word[20],
                  dlv_word[30:21], 1'b0};
    imm_b      = {{19{dlv_word[31]}}, dlv_word[31], dlv_word[7], dlv_word[30:25],
                  dlv_word[11:8], 1'b0};
    next_pc    = pc + 32'd4;
    next_stall = 1'b0;
    case (dlv_word[6:0])
      7'b1101111: next_pc = pc + imm_j;
      7'b1100011: if (PREDICT_TAKEN) next_pc = pc + imm_b;
      7'b1100111: begin
        next_pc    = pc;
        next_stall = 1'b1;
      end
      default: ;
    endcase
    deliver = _need_inst &&
              ((state == WAIT && _mem_done && !discard) || state == HOLD);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state           <= REQ;
      pc              <= RESET_PC;
      hold_buf        <= '0;
      discard         <= 1'b0;
      _mem_req        <= 1'b0;
      _mem_addr       <= '0;
      _inst_out       <= '0;
      _inst_addr_out  <= '0;
      _inst_ready_out <= 1'b0;
    end else begin
      _inst_ready_out <= 1'b0;
      if (rdy_in) begin
        if (_clear) begin
          pc <= _clear_pc;
          // An unanswered request must still be drained; its word is dropped later.
          if (state == WAIT && !_mem_done) begin
            discard <= 1'b1;
          end else begin
            discard  <= 1'b0;
            _mem_req <= 1'b0;
            state    <= REQ;
          end
        end else if (deliver) begin
          _inst_out       <= dlv_word;
          _inst_addr_out  <= pc;
          _inst_ready_out <= 1'b1;
          pc              <= next_pc;
          _mem_req        <= 1'b0;
          state           <= next_stall ? STALL : REQ;
        end else begin
          case (state)
            REQ: begin
              _mem_req  <= 1'b1;
              _mem_addr <= pc;
              state     <= WAIT;
            end
            WAIT: begin
              if (_mem_done) begin
                _mem_req <= 1'b0;
                discard  <= 1'b0;
                if (discard) begin
                  state <= REQ;
                end else begin
                  hold_buf <= _mem_data;
                  state    <= HOLD;
                end
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_inst_fetcher.sv
// Bench for inst_fetcher: a memory responder plus a stream-level model of the expected
// fetch addresses and delivered (addr, word) pairs, with directed and random phases.
module tb_inst_fetcher;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        clr;
  logic [31:0] clr_pc;
  logic        need;
  logic [31:0] inst_out;
  logic        inst_ready;
  logic [31:0] inst_addr;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic        mem_done;

  inst_fetcher #(.RESET_PC(RESET_PC), .PREDICT_TAKEN(1'b1)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    ._clear(clr), ._clear_pc(clr_pc), ._need_inst(need),
    ._inst_out(inst_out), ._inst_ready_out(inst_ready), ._inst_addr_out(inst_addr),
    ._mem_req(mem_req), ._mem_addr(mem_addr), ._mem_data(mem_data), ._mem_done(mem_done)
  );

  always #5 clk_in = ~clk_in;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- memory contents and responder ----------------
  logic [31:0] prog [logic [31:0]];
  bit          busy = 0;
  bit          mem_stall = 0;
  int          cnt, lat = 1;
  logic [31:0] req_a;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return prog.exists(a) ? prog[a] : 32'h0000_0013;
  endfunction

  task automatic mem_step();
    mem_done = 1'b0;
    if (busy) begin
      if (rdy_in && !mem_stall) begin
        if (cnt == 0) begin
          mem_done = 1'b1;
          mem_data = mem_word(req_a);
          busy     = 0;
        end else begin
          cnt--;
        end
      end
    end else if (mem_req) begin
      busy  = 1;
      req_a = mem_addr;
      cnt   = lat;
    end
  endtask

  task automatic step();
    mem_step();
    @(posedge clk_in);
    #2;
  endtask

  // ---------------- reference model (instruction stream) ----------------
  logic [31:0] exp_req [$];
  logic [31:0] exp_del [$];
  logic [31:0] req_log [$];
  bit          stalled = 0;
  int          n_deliv = 0;

  function automatic logic [31:0] ref_target(input logic [31:0] pc, input logic [31:0] w,
                                             output bit halt);
    int off;
    halt = 0;
    case (w[6:0])
      7'h6F: off = (w[31] ? -1048576 : 0) + int'(w[19:12]) * 4096 + int'(w[20]) * 2048
                   + int'(w[30:21]) * 2;
      7'h63: off = (w[31] ? -4096 : 0) + int'(w[7]) * 2048 + int'(w[30:25]) * 32
                   + int'(w[11:8]) * 2;
      7'h67: begin off = 0; halt = 1; end
      default: off = 4;
    endcase
    return pc + 32'(off);
  endfunction

  task automatic model_redirect(input logic [31:0] pc);
    exp_req.delete();
    exp_del.delete();
    exp_req.push_back(pc);
    exp_del.push_back(pc);
    stalled = 0;
  endtask

  task automatic model_after(input logic [31:0] a);
    logic [31:0] n;
    bit h;
    n = ref_target(a, mem_word(a), h);
    if (h) stalled = 1;
    else begin
      exp_req.push_back(n);
      exp_del.push_back(n);
    end
  endtask

  function automatic logic [31:0] enc_jal(input int off);
    logic [31:0] i;
    i = 32'(off);
    return {i[20], i[10:1], i[11], i[19:12], 5'd1, 7'h6F};
  endfunction

  function automatic logic [31:0] enc_beq(input int off);
    logic [31:0] i;
    i = 32'(off);
    return {i[12], i[10:5], 10'd0, 3'd0, i[4:1], i[11], 7'h63};
  endfunction

  // ---------------- monitor ----------------
  logic        prev_req = 0;
  logic        prev_ready = 0;
  logic [31:0] prev_addr = '0;
  logic [31:0] mon_a;

  always @(posedge clk_in) begin
    #1;
    if (rst_in) begin
      prev_req   = 0;
      prev_ready = 0;
    end else begin
      if (mem_req && !prev_req) begin
        req_log.push_back(mem_addr);
        check("req_pending", 32'(exp_req.size() != 0), 32'd1);
        if (exp_req.size() != 0) begin
          mon_a = exp_req.pop_front();
          check("req_addr", mem_addr, mon_a);
        end
      end
      if (mem_req && prev_req) check("addr_stable", mem_addr, prev_addr);
      if (!rdy_in) check("rdy_low_quiet", 32'(inst_ready), 32'd0);
      if (inst_ready) begin
        check("pulse_gap", 32'(prev_ready), 32'd0);
        check("need_at_pulse", 32'(need), 32'd1);
        check("del_pending", 32'(exp_del.size() != 0), 32'd1);
        if (exp_del.size() != 0) begin
          mon_a = exp_del.pop_front();
          check("del_addr", inst_addr, mon_a);
          check("del_word", inst_out, mem_word(mon_a));
          model_after(mon_a);
        end
        n_deliv++;
      end
      prev_req   = mem_req;
      prev_ready = inst_ready;
      prev_addr  = mem_addr;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  logic [31:0] exp_log [9];
  logic [31:0] cap_a, cap_ia;
  int          k, d, stall_cnt, r;

  initial begin
    exp_log = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h20, 32'h40, 32'h38, 32'h44};
    prog[32'h10] = 32'h0100006F;   // jal +16
    prog[32'h20] = 32'h0200006F;   // jal +32
    prog[32'h40] = 32'hFE000CE3;   // beq -8
    prog[32'h38] = 32'h00C0006F;   // jal +12
    prog[32'h44] = 32'h00008067;   // jalr

    rst_in = 1; rdy_in = 1; clr = 0; clr_pc = '0; need = 1;
    mem_done = 0; mem_data = '0;
    #1;
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_ready", 32'(inst_ready), 32'd0);
    check("rst_inst", inst_out, 32'd0);
    check("rst_inst_addr", inst_addr, 32'd0);
    model_redirect(RESET_PC);
    @(posedge clk_in); #2;
    @(posedge clk_in); #2;
    rst_in = 0;

    // sequential fetch, prediction, JALR stall
    k = 0;
    while (mem_done !== 1'b1 && k < 20) begin step(); k++; end
    check("first_done", 32'(mem_done), 32'd1);
    check("first_pulse", 32'(inst_ready), 32'd1);
    check("first_addr", inst_addr, 32'h0);
    check("req_drop", 32'(mem_req), 32'd0);
    step();
    check("no_double_pulse", 32'(inst_ready), 32'd0);
    check("next_req", 32'(mem_req), 32'd1);
    check("next_req_addr", mem_addr, 32'h4);
    k = 0;
    while (!stalled && k < 300) begin step(); k++; end
    check("jalr_stall", 32'(stalled), 32'd1);
    check("n_deliv", 32'(n_deliv), 32'd9);
    check("req_log_len", 32'(req_log.size()), 32'd9);
    for (int i = 0; i < 9; i++)
      if (i < req_log.size()) check("req_log", req_log[i], exp_log[i]);
    for (int i = 0; i < 10; i++) begin
      step();
      check("stall_idle", 32'(mem_req), 32'd0);
    end

    // flush out of stall, word arrives while Issue is full
    need = 0; clr = 1; clr_pc = 32'h100; model_redirect(32'h100);
    step();
    clr = 0;
    k = 0;
    while (mem_done !== 1'b1 && k < 20) begin step(); k++; end
    check("hold_done", 32'(mem_done), 32'd1);
    check("hold_no_pulse", 32'(inst_ready), 32'd0);
    d = n_deliv;
    for (int i = 0; i < 5; i++) begin
      step();
      check("hold_wait", 32'(inst_ready), 32'd0);
    end
    need = 1;
    step();
    check("hold_pulse", 32'(inst_ready), 32'd1);
    check("hold_addr", inst_addr, 32'h100);
    check("hold_word", inst_out, 32'h0000_0013);
    step();
    check("hold_single", 32'(inst_ready), 32'd0);
    check("hold_count", 32'(n_deliv), 32'(d + 1));

    // flush with a request outstanding
    lat = 3; clr = 1; clr_pc = 32'h8; model_redirect(32'h8);
    step();
    clr = 0;
    k = 0;
    while (!(mem_req && mem_addr == 32'h8) && k < 40) begin step(); k++; end
    check("req_at_8", mem_addr, 32'h8);
    clr = 1; clr_pc = 32'h200; model_redirect(32'h200);
    d = n_deliv;
    step();
    clr = 0;
    k = 0;
    while (n_deliv == d && k < 60) begin step(); k++; end
    check("flush_count", 32'(n_deliv), 32'(d + 1));
    check("flush_addr", inst_addr, 32'h200);

    // rdy_in low while waiting for memory
    lat = 1; mem_stall = 1;
    k = 0;
    while (mem_req && k < 20) begin step(); k++; end
    k = 0;
    while (!mem_req && k < 20) begin step(); k++; end
    check("rdy_req_seen", 32'(mem_req), 32'd1);
    cap_a = mem_addr; cap_ia = inst_addr;
    rdy_in = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("frz_req", 32'(mem_req), 32'd1);
      check("frz_addr", mem_addr, cap_a);
      check("frz_inst_addr", inst_addr, cap_ia);
      check("frz_ready", 32'(inst_ready), 32'd0);
    end
    rdy_in = 1; mem_stall = 0;
    d = n_deliv;
    k = 0;
    while (n_deliv == d && k < 20) begin step(); k++; end
    check("resume_addr", inst_addr, cap_a);

    // asynchronous reset in the middle of a fetch
    mem_stall = 1;
    k = 0;
    while (mem_req && k < 20) begin step(); k++; end
    k = 0;
    while (!mem_req && k < 20) begin step(); k++; end
    rst_in = 1; busy = 0; mem_done = 0;
    #1;
    check("arst_req", 32'(mem_req), 32'd0);
    check("arst_addr", mem_addr, 32'd0);
    check("arst_ready", 32'(inst_ready), 32'd0);
    check("arst_inst_addr", inst_addr, 32'd0);
    model_redirect(RESET_PC);
    @(posedge clk_in); #2;
    @(posedge clk_in); #2;
    rst_in = 0; mem_stall = 0;
    k = 0;
    while (!mem_req && k < 20) begin step(); k++; end
    check("arst_next_req", mem_addr, RESET_PC);

    // random program, latency, back-pressure, stalls and flushes
    for (int i = 0; i < 64; i++) begin
      r = $urandom_range(0, 19);
      if (r < 10)      prog[32'h300 + 32'(i * 4)] = 32'h0000_0013;
      else if (r < 14) prog[32'h300 + 32'(i * 4)] = enc_jal(($urandom_range(0, 16) - 8) * 4);
      else if (r < 18) prog[32'h300 + 32'(i * 4)] = enc_beq(($urandom_range(0, 16) - 8) * 4);
      else             prog[32'h300 + 32'(i * 4)] = 32'h00008067;
    end
    stall_cnt = 0;
    for (int c = 0; c < 3000; c++) begin
      rdy_in = ($urandom_range(0, 7) != 0);
      need   = ($urandom_range(0, 3) != 0);
      lat    = $urandom_range(0, 3);
      clr    = 0;
      stall_cnt = stalled ? stall_cnt + 1 : 0;
      if (rdy_in && (stall_cnt > 4 || $urandom_range(0, 99) == 0)) begin
        clr    = 1;
        clr_pc = 32'h300 + 32'($urandom_range(0, 63)) * 4;
        model_redirect(clr_pc);
        stall_cnt = 0;
      end
      step();
    end
    rdy_in = 1; clr = 0; need = 1;
    for (int i = 0; i < 10; i++) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
